// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
package mem_arb_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam logic [3:0] FULL_WORD_MASK = 4'b1111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IBUSY = 2'd1,
        DBUSY = 2'd2
    } arb_state_e;

    typedef enum logic {
        IMEM = 1'b0,
        DMEM = 1'b1
    } grant_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and shared-memory bus bundle; slave is the arbiter's view, master the environment's.
interface mem_port_arbiter_if;
    import mem_arb_pkg::*;

    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ready;
    logic [DATA_W-1:0] imem_rdata;

    logic              dmem_req;
    logic [ADDR_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic              dmem_write;
    logic [3:0]        dmem_size;
    logic              dmem_ready;
    logic [DATA_W-1:0] dmem_rdata;

    logic              mem_valid;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_write;
    logic [3:0]        mem_size;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  imem_req, imem_addr,
        input  dmem_req, dmem_addr, dmem_wdata, dmem_write, dmem_size,
        input  mem_ready, mem_rdata,
        output imem_ready, imem_rdata, dmem_ready, dmem_rdata,
        output mem_valid, mem_addr, mem_wdata, mem_write, mem_size
    );

    modport master (
        output imem_req, imem_addr,
        output dmem_req, dmem_addr, dmem_wdata, dmem_write, dmem_size,
        output mem_ready, mem_rdata,
        input  imem_ready, imem_rdata, dmem_ready, dmem_rdata,
        input  mem_valid, mem_addr, mem_wdata, mem_write, mem_size
    );

endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter merging an instruction-fetch and a data port onto one memory bus.
// Optional bus-timeout abort is enabled with the MEM_ARB_TIMEOUT_EN macro.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clock,
    input  logic              reset_n,
    mem_port_arbiter_if.slave bus,
    output logic              timeout_err
);

    arb_state_e        state_reg;
    grant_e            last_grant_reg;
    logic              mem_valid_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic [DATA_W-1:0] mem_wdata_reg;
    logic              mem_write_reg;
    logic [3:0]        mem_size_reg;

    logic busy;
    logic grant_i;
    logic grant_d;
    logic timeout_hit;
    logic done;

    // On a tie the port that did not win last time gets the bus.
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (state_reg == IDLE) begin
            if (bus.imem_req && (!bus.dmem_req || last_grant_reg == DMEM)) begin
                grant_i = 1'b1;
            end else if (bus.dmem_req) begin
                grant_d = 1'b1;
            end
        end
    end

    assign busy = (state_reg == IBUSY) || (state_reg == DBUSY);
    assign done = busy && (bus.mem_ready || timeout_hit);

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] timeout_cnt_reg;
    logic             timeout_err_reg;

    assign timeout_hit = busy && !bus.mem_ready && (timeout_cnt_reg >= CNT_W'(TIMEOUT_CYCLES));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            timeout_cnt_reg <= '0;
            timeout_err_reg <= 1'b0;
        end else begin
            if (grant_i || grant_d) begin
                timeout_cnt_reg <= '0;
            end else if (busy && !bus.mem_ready && !timeout_hit) begin
                timeout_cnt_reg <= timeout_cnt_reg + CNT_W'(1);
            end
            if (timeout_hit) begin
                timeout_err_reg <= 1'b1;
            end
        end
    end

    assign timeout_err = timeout_err_reg;
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign timeout_hit        = 1'b0;
    assign timeout_err        = 1'b0;
`endif

    // Request fields are captured only at grant, so requester inputs may wander while busy.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            last_grant_reg <= DMEM;
            mem_valid_reg  <= 1'b0;
            mem_addr_reg   <= '0;
            mem_wdata_reg  <= '0;
            mem_write_reg  <= 1'b0;
            mem_size_reg   <= 4'b0000;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (grant_i) begin
                        state_reg      <= IBUSY;
                        last_grant_reg <= IMEM;
                        mem_valid_reg  <= 1'b1;
                        mem_addr_reg   <= bus.imem_addr;
                        mem_wdata_reg  <= '0;
                        mem_write_reg  <= 1'b0;
                        mem_size_reg   <= FULL_WORD_MASK;
                    end else if (grant_d) begin
                        state_reg      <= DBUSY;
                        last_grant_reg <= DMEM;
                        mem_valid_reg  <= 1'b1;
                        mem_addr_reg   <= bus.dmem_addr;
                        mem_wdata_reg  <= bus.dmem_wdata;
                        mem_write_reg  <= bus.dmem_write;
                        mem_size_reg   <= bus.dmem_size;
                    end
                end
                IBUSY, DBUSY: begin
                    if (done) begin
                        state_reg     <= IDLE;
                        mem_valid_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    mem_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mem_valid = mem_valid_reg;
    assign bus.mem_addr  = mem_addr_reg;
    assign bus.mem_wdata = mem_wdata_reg;
    assign bus.mem_write = mem_write_reg;
    assign bus.mem_size  = mem_size_reg;

    // A timeout completion returns zero data because mem_ready is low in that cycle.
    assign bus.imem_ready = (state_reg == IBUSY) && done;
    assign bus.dmem_ready = (state_reg == DBUSY) && done;
    assign bus.imem_rdata = ((state_reg == IBUSY) && bus.mem_ready) ? bus.mem_rdata : '0;
    assign bus.dmem_rdata = ((state_reg == DBUSY) && bus.mem_ready) ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter; timeout scenario runs when MEM_ARB_TIMEOUT_EN is defined.
module tb_mem_port_arbiter;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int TO_CYC = 4;
`else
    localparam int TO_CYC = 255;
`endif

    typedef struct {
        logic        is_d;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        write;
        logic [3:0]  size;
        logic [31:0] rdata;
    } txn_t;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic timeout_err;

    mem_port_arbiter_if bus ();

    mem_port_arbiter #(.TIMEOUT_CYCLES(TO_CYC)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .bus         (bus.slave),
        .timeout_err (timeout_err)
    );

    always #5 clock = ~clock;

    int   n_vec  = 0;
    int   n_miss = 0;
    int   n_txn  = 0;
    txn_t i_q[$];
    txn_t d_q[$];
    logic grant_log[$];
    int   i_done = 0;
    int   d_done = 0;
    logic i_hit = 1'b0;
    logic d_hit = 1'b0;
    int   i_todo = 0;
    int   d_todo = 0;
    logic resp_en = 1'b1;
    int   resp_delay = 0;
    int   wait_cnt = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_model(input logic [31:0] a);
        return a ^ 32'h0000_0003;
    endfunction

    task automatic issue_i(input logic [31:0] addr);
        txn_t e;
        bus.imem_req  = 1'b1;
        bus.imem_addr = addr;
        e.is_d = 1'b0; e.addr = addr; e.wdata = '0; e.write = 1'b0;
        e.size = 4'b1111; e.rdata = mem_model(addr);
        i_q.push_back(e);
    endtask

    task automatic issue_d(input logic [31:0] addr, input logic [31:0] wdata,
                           input logic write, input logic [3:0] size);
        txn_t e;
        bus.dmem_req   = 1'b1;
        bus.dmem_addr  = addr;
        bus.dmem_wdata = wdata;
        bus.dmem_write = write;
        bus.dmem_size  = size;
        e.is_d = 1'b1; e.addr = addr; e.wdata = wdata; e.write = write;
        e.size = size; e.rdata = mem_model(addr);
        d_q.push_back(e);
    endtask

    task automatic check_txn(input txn_t e, input logic [31:0] rdata);
        check_val("txn_valid", {31'd0, bus.mem_valid}, 32'd1);
        check_val("txn_addr",  bus.mem_addr, e.addr);
        check_val("txn_wdata", bus.mem_wdata, e.wdata);
        check_val("txn_write", {31'd0, bus.mem_write}, {31'd0, e.write});
        check_val("txn_size",  {28'd0, bus.mem_size}, {28'd0, e.size});
        check_val("txn_rdata", rdata, e.rdata);
        n_txn++;
        $display("txn %0d port=%s addr=%h wr=%0d size=%b rdata=%h", n_txn,
                 e.is_d ? "D" : "I", bus.mem_addr, bus.mem_write, bus.mem_size, rdata);
    endtask

    // Scoreboard monitor: pops expected transactions on each completion pulse.
    always @(negedge clock) begin
        txn_t e;
        if (reset_n) begin
            if (bus.imem_ready && bus.dmem_ready) check_val("dual_ready", 32'd1, 32'd0);
            if (bus.imem_ready) begin
                if (i_q.size() == 0) check_val("i_unexpected", 32'd1, 32'd0);
                else begin e = i_q.pop_front(); check_txn(e, bus.imem_rdata); end
                grant_log.push_back(1'b0);
                i_done++;
                i_hit = 1'b1;
            end else check_val("i_rdata_idle", bus.imem_rdata, 32'd0);
            if (bus.dmem_ready) begin
                if (d_q.size() == 0) check_val("d_unexpected", 32'd1, 32'd0);
                else begin e = d_q.pop_front(); check_txn(e, bus.dmem_rdata); end
                grant_log.push_back(1'b1);
                d_done++;
                d_hit = 1'b1;
            end else check_val("d_rdata_idle", bus.dmem_rdata, 32'd0);
        end
    end

    // Requesters: drop or re-issue after each completion.
    always @(posedge clock) begin
        #1;
        if (i_hit) begin
            i_hit = 1'b0;
            if (i_todo > 0) begin i_todo--; issue_i(bus.imem_addr + 32'd4); end
            else bus.imem_req = 1'b0;
        end
        if (d_hit) begin
            d_hit = 1'b0;
            if (d_todo > 0) begin
                d_todo--;
                issue_d(bus.dmem_addr + 32'd4, bus.dmem_wdata + 32'd1, bus.dmem_write, bus.dmem_size);
            end else bus.dmem_req = 1'b0;
        end
    end

    // Memory responder: answers after resp_delay wait cycles.
    always @(posedge clock) begin
        #1;
        if (resp_en) begin
            if (bus.mem_valid) begin
                if (wait_cnt >= resp_delay) begin
                    bus.mem_ready = 1'b1;
                    bus.mem_rdata = mem_model(bus.mem_addr);
                end else begin
                    bus.mem_ready = 1'b0;
                    wait_cnt++;
                end
            end else begin
                bus.mem_ready = 1'b0;
                bus.mem_rdata = 32'hFFFF_FFFF;
                wait_cnt = 0;
            end
        end
    end

    task automatic wait_done(input int target, input int budget);
        int n = 0;
        while ((i_done + d_done) < target && n < budget) begin
            @(negedge clock);
            n++;
        end
        if ((i_done + d_done) < target) check_val("wait_budget", i_done + d_done, target);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        bus.imem_req = 1'b0;
        bus.dmem_req = 1'b0;
        i_q.delete();
        d_q.delete();
        i_hit = 1'b0; d_hit = 1'b0;
        i_todo = 0; d_todo = 0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        int s;
        int i0;
        int d0;
        bus.imem_req = 1'b0; bus.imem_addr = '0;
        bus.dmem_req = 1'b0; bus.dmem_addr = '0; bus.dmem_wdata = '0;
        bus.dmem_write = 1'b0; bus.dmem_size = '0;
        bus.mem_ready = 1'b0; bus.mem_rdata = '0;

        // Reset values
        @(negedge clock);
        check_val("rst_valid", {31'd0, bus.mem_valid}, 32'd0);
        check_val("rst_addr",  bus.mem_addr, 32'd0);
        check_val("rst_wdata", bus.mem_wdata, 32'd0);
        check_val("rst_write", {31'd0, bus.mem_write}, 32'd0);
        check_val("rst_size",  {28'd0, bus.mem_size}, 32'd0);
        check_val("rst_terr",  {31'd0, timeout_err}, 32'd0);
        do_reset();

        // Single fetch: mem_valid and imem_ready in cycle 1
        @(posedge clock); #1;
        issue_i(32'h0000_0010);
        @(negedge clock);
        check_val("c0_valid", {31'd0, bus.mem_valid}, 32'd0);
        @(negedge clock);
        check_val("c1_valid", {31'd0, bus.mem_valid}, 32'd1);
        check_val("c1_iready", {31'd0, bus.imem_ready}, 32'd1);
        check_val("c1_irdata", bus.imem_rdata, 32'h0000_0013);
        wait_done(1, 20);
        repeat (2) @(negedge clock);

        // mem_ready in IDLE is ignored
        @(posedge clock); #1;
        resp_en = 1'b0;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h1234_5678;
        @(negedge clock);
        check_val("idle_iready", {31'd0, bus.imem_ready}, 32'd0);
        check_val("idle_dready", {31'd0, bus.dmem_ready}, 32'd0);
        @(posedge clock); #1;
        bus.mem_ready = 1'b0;
        resp_en = 1'b1;

        // Contested from reset: IMem first, then the store
        do_reset();
        s = grant_log.size(); i0 = i_done; d0 = d_done;
        @(posedge clock); #1;
        issue_i(32'h0000_0200);
        issue_d(32'h0000_0100, 32'hDEAD_BEEF, 1'b1, 4'b0011);
        wait_done(i_done + d_done + 2, 30);
        repeat (4) @(negedge clock);
        check_val("both_icount", i_done - i0, 32'd1);
        check_val("both_dcount", d_done - d0, 32'd1);
        if (grant_log.size() >= s + 2) begin
            check_val("both_first_i",  {31'd0, grant_log[s]},     32'd0);
            check_val("both_second_d", {31'd0, grant_log[s + 1]}, 32'd1);
        end else check_val("both_log_len", grant_log.size() - s, 32'd2);

        // Ten back-to-back contested transactions alternate
        s = grant_log.size(); i0 = i_done; d0 = d_done;
        @(posedge clock); #1;
        i_todo = 4; d_todo = 4;
        issue_i(32'h0000_1000);
        issue_d(32'h0000_2000, 32'h0000_0AA0, 1'b0, 4'b1111);
        wait_done(i_done + d_done + 10, 80);
        repeat (3) @(negedge clock);
        check_val("rr_icount", i_done - i0, 32'd5);
        check_val("rr_dcount", d_done - d0, 32'd5);
        for (int k = 0; k < 10; k++) begin
            if (s + k < grant_log.size())
                check_val("rr_order", {31'd0, grant_log[s + k]}, k % 2);
        end

        // Stalled DBUSY with wandering dmem_addr
        resp_delay = 3;
        @(posedge clock); #1;
        issue_d(32'h0000_0300, 32'h0000_5555, 1'b0, 4'b1100);
        @(negedge clock);
        for (int k = 1; k <= 4; k++) begin
            @(posedge clock); #1;
            bus.dmem_addr = 32'hBAD0_0000 + k;
            @(negedge clock);
            check_val("stall_addr", bus.mem_addr, 32'h0000_0300);
            check_val("stall_dready", {31'd0, bus.dmem_ready}, (k == 4) ? 32'd1 : 32'd0);
        end
        repeat (3) @(negedge clock);

        // Withdrawn fetch still completes
        resp_delay = 2;
        i0 = i_done;
        @(posedge clock); #1;
        issue_i(32'h0000_0400);
        @(posedge clock); #1;
        @(posedge clock); #1;
        bus.imem_req = 1'b0;
        wait_done(i_done + d_done + 1, 20);
        check_val("withdraw_done", i_done - i0, 32'd1);
        repeat (2) @(negedge clock);

        // Reset mid-IBUSY drops the fetch; round-robin restarts at IMem
        resp_delay = 5;
        i0 = i_done;
        @(posedge clock); #1;
        issue_i(32'h0000_0500);
        repeat (2) @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        check_val("rst_mid_valid",  {31'd0, bus.mem_valid}, 32'd0);
        check_val("rst_mid_iready", {31'd0, bus.imem_ready}, 32'd0);
        do_reset();
        check_val("rst_mid_nodone", i_done - i0, 32'd0);
        resp_delay = 0;
        s = grant_log.size();
        @(posedge clock); #1;
        issue_i(32'h0000_0600);
        issue_d(32'h0000_0700, 32'h0000_0777, 1'b1, 4'b0001);
        wait_done(i_done + d_done + 2, 30);
        if (grant_log.size() >= s + 1)
            check_val("post_rst_first_i", {31'd0, grant_log[s]}, 32'd0);
        else check_val("post_rst_log_len", grant_log.size() - s, 32'd1);
        repeat (3) @(negedge clock);

`ifdef MEM_ARB_TIMEOUT_EN
        // Bus timeout: never answer, zero data after 4 silent busy cycles
        check_val("terr_before", {31'd0, timeout_err}, 32'd0);
        @(posedge clock); #1;
        resp_en = 1'b0;
        bus.mem_ready = 1'b0;
        issue_d(32'h0000_0800, 32'h0000_0888, 1'b0, 4'b1111);
        d_q[d_q.size() - 1].rdata = 32'd0;
        @(negedge clock);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clock);
            check_val("to_dready", {31'd0, bus.dmem_ready}, (k == 5) ? 32'd1 : 32'd0);
        end
        @(negedge clock);
        check_val("terr_set", {31'd0, timeout_err}, 32'd1);
        check_val("to_valid_clr", {31'd0, bus.mem_valid}, 32'd0);
        resp_en = 1'b1;
        @(posedge clock); #1;
        issue_i(32'h0000_0900);
        wait_done(i_done + d_done + 1, 20);
        repeat (2) @(negedge clock);
        check_val("terr_sticky", {31'd0, timeout_err}, 32'd1);
`else
        check_val("terr_tied", {31'd0, timeout_err}, 32'd0);
`endif

        check_val("iq_empty", i_q.size(), 32'd0);
        check_val("dq_empty", d_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
